// File: rtl/mem_vio_arb.sv
// mem_vio_arb - memory-ordering violation arbiter.
//
// Collects load/store ordering violations from the store-issue pipes. It keeps
// the single oldest unresolved violating load and holds a squash request for it
// to the ROB. When the ROB acknowledges the squash, it sends a one-cycle
// violation update carrying the store/load fold-PCs to the memdep predictor.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   i_rpt_vld              [PORTS]          per-pipe violation report valid
//   i_rpt_load_robIdx      [PORTS*ROB_W]    violating load ROB index, pipe p at [p*ROB_W +: ROB_W]
//   i_rpt_store_foldpc     [PORTS*FOLDPC_W] store fold-PC per pipe
//   i_rpt_load_foldpc      [PORTS*FOLDPC_W] load fold-PC per pipe
//   i_flush, i_flush_robIdx                 redirect killing that entry and all younger ones
//   o_squash_vld, o_squash_robIdx           squash request, held until i_squash_ack
//   i_squash_ack                            ROB accepts the squash
//   o_violation, o_vio_store_foldpc, o_vio_load_foldpc   one-cycle predictor update
//   o_vio_count            [32]             saturating violation count (MEMVIO_CNT_EN only)
//
// A ROB index is {flag, idx}: the MSB is the wrap flag, the rest is the slot.
// Optional feature: define MEMVIO_CNT_EN to add the o_vio_count counter/port.

`ifndef STORE_ISSUE_WIDTH
`define STORE_ISSUE_WIDTH 2
`endif
`ifndef MEMDEP_FOLDPC_WIDTH
`define MEMDEP_FOLDPC_WIDTH 10
`endif

module mem_vio_arb #(
  parameter int PORTS    = `STORE_ISSUE_WIDTH,
  parameter int FOLDPC_W = `MEMDEP_FOLDPC_WIDTH,
  parameter int ROB_W    = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PORTS-1:0]          i_rpt_vld,
  input  logic [PORTS*ROB_W-1:0]    i_rpt_load_robIdx,
  input  logic [PORTS*FOLDPC_W-1:0] i_rpt_store_foldpc,
  input  logic [PORTS*FOLDPC_W-1:0] i_rpt_load_foldpc,
  input  logic                      i_flush,
  input  logic [ROB_W-1:0]          i_flush_robIdx,
  output logic                      o_squash_vld,
  output logic [ROB_W-1:0]          o_squash_robIdx,
  input  logic                      i_squash_ack,
  output logic                      o_violation,
  output logic [FOLDPC_W-1:0]       o_vio_store_foldpc,
  output logic [FOLDPC_W-1:0]       o_vio_load_foldpc
`ifdef MEMVIO_CNT_EN
  ,
  output logic [31:0]               o_vio_count
`endif
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t state, nxt_state;

  logic [ROB_W-1:0]    pend_rob;
  logic [FOLDPC_W-1:0] pend_spc, pend_lpc;

  logic                cand_vld;
  logic [ROB_W-1:0]    cand_rob;
  logic [FOLDPC_W-1:0] cand_spc, cand_lpc;

  logic                capture;
  logic                fire;
  logic                vio_vld_p1;
  logic [FOLDPC_W-1:0] vio_spc_p1, vio_lpc_p1;

  // a is strictly older than b; equal indices are the same entry.
  function automatic logic is_older(input logic [ROB_W-1:0] a, input logic [ROB_W-1:0] b);
    if (a[ROB_W-1] == b[ROB_W-1]) return a[ROB_W-2:0] < b[ROB_W-2:0];
    else                          return a[ROB_W-2:0] > b[ROB_W-2:0];
  endfunction

  // x is killed when a flush targets x itself or an entry older than x.
  function automatic logic is_killed(input logic fl, input logic [ROB_W-1:0] frob,
                                     input logic [ROB_W-1:0] x);
    return fl && ((x == frob) || is_older(frob, x));
  endfunction

  // Oldest surviving report; strict comparison lets the lower port win ties.
  always_comb begin
    cand_vld = 1'b0;
    cand_rob = '0;
    cand_spc = '0;
    cand_lpc = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (i_rpt_vld[p] &&
          !is_killed(i_flush, i_flush_robIdx, i_rpt_load_robIdx[p*ROB_W +: ROB_W]) &&
          (!cand_vld || is_older(i_rpt_load_robIdx[p*ROB_W +: ROB_W], cand_rob))) begin
        cand_vld = 1'b1;
        cand_rob = i_rpt_load_robIdx[p*ROB_W +: ROB_W];
        cand_spc = i_rpt_store_foldpc[p*FOLDPC_W +: FOLDPC_W];
        cand_lpc = i_rpt_load_foldpc[p*FOLDPC_W +: FOLDPC_W];
      end
    end
  end

  always_comb begin
    nxt_state = state;
    capture   = 1'b0;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        if (cand_vld) begin
          capture   = 1'b1;
          nxt_state = PEND;
        end
      end
      PEND: begin
        if (is_killed(i_flush, i_flush_robIdx, pend_rob)) begin
          // A killed squash target is simply dropped; any ack this cycle is moot.
          capture   = cand_vld;
          nxt_state = cand_vld ? PEND : IDLE;
        end else if (i_squash_ack) begin
          fire = 1'b1;
          if (cand_vld && is_older(cand_rob, pend_rob)) capture = 1'b1;
          else                                          nxt_state = IDLE;
        end else if (cand_vld && is_older(cand_rob, pend_rob)) begin
          capture = 1'b1;
        end
        // Same-or-younger reports are dropped: the pending squash re-executes them.
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Stage p0: FSM state and pending slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pend_rob <= '0;
      pend_spc <= '0;
      pend_lpc <= '0;
    end else begin
      state <= nxt_state;
      if (capture) begin
        pend_rob <= cand_rob;
        pend_spc <= cand_spc;
        pend_lpc <= cand_lpc;
      end
    end
  end

  // Stage p1: one-cycle predictor update after the ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      vio_vld_p1 <= 1'b0;
      vio_spc_p1 <= '0;
      vio_lpc_p1 <= '0;
    end else begin
      vio_vld_p1 <= fire;
      if (fire) begin
        vio_spc_p1 <= pend_spc;
        vio_lpc_p1 <= pend_lpc;
      end
    end
  end

  assign o_squash_vld       = (state == PEND);
  assign o_squash_robIdx    = pend_rob;
  // Reset in the pulse cycle must also cancel the already-registered pulse.
  assign o_violation        = vio_vld_p1 && !rst;
  assign o_vio_store_foldpc = vio_spc_p1;
  assign o_vio_load_foldpc  = vio_lpc_p1;

`ifdef MEMVIO_CNT_EN
  logic [31:0] vio_cnt;

  always_ff @(posedge clk) begin
    if (rst)                          vio_cnt <= '0;
    else if (fire && (vio_cnt != '1)) vio_cnt <= vio_cnt + 32'd1;
  end

  assign o_vio_count = vio_cnt;
`endif

endmodule

// File: tb/tb_mem_vio_arb.sv
// tb_mem_vio_arb - directed table-driven bench for mem_vio_arb (2 ports,
// 10-bit fold-PCs, 7-bit ROB index {flag, idx[5:0]}).
module tb_mem_vio_arb;

  localparam int PORTS    = 2;
  localparam int FOLDPC_W = 10;
  localparam int ROB_W    = 7;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [PORTS-1:0]          i_rpt_vld;
  logic [PORTS*ROB_W-1:0]    i_rpt_load_robIdx;
  logic [PORTS*FOLDPC_W-1:0] i_rpt_store_foldpc;
  logic [PORTS*FOLDPC_W-1:0] i_rpt_load_foldpc;
  logic                      i_flush;
  logic [ROB_W-1:0]          i_flush_robIdx;
  logic                      o_squash_vld;
  logic [ROB_W-1:0]          o_squash_robIdx;
  logic                      i_squash_ack;
  logic                      o_violation;
  logic [FOLDPC_W-1:0]       o_vio_store_foldpc;
  logic [FOLDPC_W-1:0]       o_vio_load_foldpc;
`ifdef MEMVIO_CNT_EN
  logic [31:0]               o_vio_count;
`endif

  mem_vio_arb #(.PORTS(PORTS), .FOLDPC_W(FOLDPC_W), .ROB_W(ROB_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .i_rpt_vld          (i_rpt_vld),
    .i_rpt_load_robIdx  (i_rpt_load_robIdx),
    .i_rpt_store_foldpc (i_rpt_store_foldpc),
    .i_rpt_load_foldpc  (i_rpt_load_foldpc),
    .i_flush            (i_flush),
    .i_flush_robIdx     (i_flush_robIdx),
    .o_squash_vld       (o_squash_vld),
    .o_squash_robIdx    (o_squash_robIdx),
    .i_squash_ack       (i_squash_ack),
    .o_violation        (o_violation),
    .o_vio_store_foldpc (o_vio_store_foldpc),
    .o_vio_load_foldpc  (o_vio_load_foldpc)
`ifdef MEMVIO_CNT_EN
    ,
    .o_vio_count        (o_vio_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       vld;
    logic [ROB_W-1:0] rob0;
    logic [ROB_W-1:0] rob1;
    logic             flush;
    logic [ROB_W-1:0] frob;
    logic             ack;
    logic             rst;
    logic             e_sv;
    logic [ROB_W-1:0] e_rob;
    logic             e_vio;
    int               e_port;
    logic [ROB_W-1:0] e_vrob;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [ROB_W-1:0] r(input int f, input int i);
    logic [ROB_W-1:0] v;
    v = {f[0], i[5:0]};
    return v;
  endfunction

  // Each report's fold-PCs are tagged with its port and ROB index.
  function automatic logic [FOLDPC_W-1:0] sp(input int p, input logic [ROB_W-1:0] rob);
    return (p != 0) ? {3'b101, rob} : {3'b001, rob};
  endfunction
  function automatic logic [FOLDPC_W-1:0] lp(input int p, input logic [ROB_W-1:0] rob);
    return (p != 0) ? {3'b110, rob} : {3'b010, rob};
  endfunction

  task automatic add(input logic [1:0] vld, input logic [ROB_W-1:0] rob0, input logic [ROB_W-1:0] rob1,
                     input logic flush, input logic [ROB_W-1:0] frob, input logic ack, input logic rs,
                     input logic e_sv, input logic [ROB_W-1:0] e_rob, input logic e_vio,
                     input int e_port, input logic [ROB_W-1:0] e_vrob);
    vec_t v;
    v.vld = vld; v.rob0 = rob0; v.rob1 = rob1; v.flush = flush; v.frob = frob;
    v.ack = ack; v.rst = rs; v.e_sv = e_sv; v.e_rob = e_rob; v.e_vio = e_vio;
    v.e_port = e_port; v.e_vrob = e_vrob;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] vld, input logic [ROB_W-1:0] rob0, input logic [ROB_W-1:0] rob1,
                       input logic flush, input logic [ROB_W-1:0] frob, input logic ack, input logic rs);
    i_rpt_vld          = vld;
    i_rpt_load_robIdx  = {rob1, rob0};
    i_rpt_store_foldpc = {sp(1, rob1), sp(0, rob0)};
    i_rpt_load_foldpc  = {lp(1, rob1), lp(0, rob0)};
    i_flush            = flush;
    i_flush_robIdx     = frob;
    i_squash_ack       = ack;
    rst                = rs;
  endtask

  // Apply inputs for one cycle, check outputs just after the closing edge.
  task automatic step(input vec_t v, input int k);
    @(negedge clk);
    drive(v.vld, v.rob0, v.rob1, v.flush, v.frob, v.ack, v.rst);
    @(posedge clk);
    #1;
    chk($sformatf("row%0d squash_vld", k), 32'(o_squash_vld), 32'(v.e_sv));
    if (v.e_sv) chk($sformatf("row%0d squash_robIdx", k), 32'(o_squash_robIdx), 32'(v.e_rob));
    chk($sformatf("row%0d violation", k), 32'(o_violation), 32'(v.e_vio));
    if (v.e_vio) begin
      chk($sformatf("row%0d vio_store_foldpc", k), 32'(o_vio_store_foldpc), 32'(sp(v.e_port, v.e_vrob)));
      chk($sformatf("row%0d vio_load_foldpc", k), 32'(o_vio_load_foldpc), 32'(lp(v.e_port, v.e_vrob)));
    end
  endtask

  task automatic cyc(input logic [1:0] vld, input logic [ROB_W-1:0] rob0, input logic ack, input logic rs);
    @(negedge clk);
    drive(vld, rob0, '0, 1'b0, '0, ack, rs);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [ROB_W-1:0] z;
    z = '0;
    drive(2'b00, z, z, 1'b0, z, 1'b0, 1'b1);

    // vld  rob0      rob1      fl  frob      ack rst  sv  rob       vio port vrob
    add(2'b01, r(0,5),  z,       0, z,       0, 0,   1, r(0,5),  0, 0, z);        // single report
    add(2'b00, z,       z,       0, z,       0, 0,   1, r(0,5),  0, 0, z);
    add(2'b00, z,       z,       0, z,       0, 0,   1, r(0,5),  0, 0, z);
    add(2'b00, z,       z,       0, z,       1, 0,   0, z,       1, 0, r(0,5));
    add(2'b00, z,       z,       0, z,       0, 0,   0, z,       0, 0, z);
    add(2'b11, r(0,9),  r(0,4),  0, z,       0, 0,   1, r(0,4),  0, 0, z);        // oldest wins
    add(2'b00, z,       z,       0, z,       1, 0,   0, z,       1, 1, r(0,4));
    add(2'b11, r(0,4),  r(0,4),  0, z,       0, 0,   1, r(0,4),  0, 0, z);        // tie -> port0
    add(2'b00, z,       z,       0, z,       1, 0,   0, z,       1, 0, r(0,4));
    add(2'b01, r(0,20), z,       0, z,       0, 0,   1, r(0,20), 0, 0, z);        // replace / drop
    add(2'b10, z,       r(0,12), 0, z,       0, 0,   1, r(0,12), 0, 0, z);
    add(2'b01, r(0,30), z,       0, z,       0, 0,   1, r(0,12), 0, 0, z);
    add(2'b00, z,       z,       0, z,       1, 0,   0, z,       1, 1, r(0,12));
    add(2'b01, r(0,60), z,       0, z,       0, 0,   1, r(0,60), 0, 0, z);        // wrap
    add(2'b10, z,       r(1,2),  0, z,       0, 0,   1, r(0,60), 0, 0, z);
    add(2'b00, z,       z,       0, z,       1, 0,   0, z,       1, 0, r(0,60));
    add(2'b10, z,       r(1,2),  0, z,       0, 0,   1, r(1,2),  0, 0, z);
    add(2'b01, r(0,60), z,       0, z,       0, 0,   1, r(0,60), 0, 0, z);
    add(2'b00, z,       z,       0, z,       1, 0,   0, z,       1, 0, r(0,60));
    add(2'b01, r(0,7),  z,       0, z,       0, 0,   1, r(0,7),  0, 0, z);        // flush kills + ack
    add(2'b00, z,       z,       1, r(0,3),  1, 0,   0, z,       0, 0, z);
    add(2'b00, z,       z,       0, z,       0, 0,   0, z,       0, 0, z);
    add(2'b01, r(0,7),  z,       0, z,       0, 0,   1, r(0,7),  0, 0, z);
    add(2'b00, z,       z,       1, r(0,8),  0, 0,   1, r(0,7),  0, 0, z);        // flush younger
    add(2'b00, z,       z,       0, z,       1, 0,   0, z,       1, 0, r(0,7));
    add(2'b11, r(0,10), r(0,11), 1, r(0,10), 0, 0,   0, z,       0, 0, z);        // reports killed
    add(2'b11, r(0,10), r(0,11), 1, r(0,11), 0, 0,   1, r(0,10), 0, 0, z);
    add(2'b10, z,       r(0,9),  1, r(0,10), 0, 0,   1, r(0,9),  0, 0, z);        // kill + recapture
    add(2'b10, z,       r(0,3),  0, z,       1, 0,   1, r(0,3),  1, 1, r(0,9));   // ack + older
    add(2'b00, z,       z,       0, z,       1, 0,   0, z,       1, 1, r(0,3));
    add(2'b01, r(0,1),  z,       0, z,       0, 0,   1, r(0,1),  0, 0, z);        // back-to-back
    add(2'b00, z,       z,       0, z,       1, 0,   0, z,       1, 0, r(0,1));
    add(2'b01, r(0,5),  z,       0, z,       0, 0,   1, r(0,5),  0, 0, z);        // reset in PEND
    add(2'b00, z,       z,       0, z,       1, 1,   0, z,       0, 0, z);
    add(2'b00, z,       z,       0, z,       0, 0,   0, z,       0, 0, z);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset squash_vld", 32'(o_squash_vld), 32'd0);
    chk("reset squash_robIdx", 32'(o_squash_robIdx), 32'd0);
    chk("reset violation", 32'(o_violation), 32'd0);
    chk("reset vio_store_foldpc", 32'(o_vio_store_foldpc), 32'd0);
    chk("reset vio_load_foldpc", 32'(o_vio_load_foldpc), 32'd0);
`ifdef MEMVIO_CNT_EN
    chk("reset vio_count", o_vio_count, 32'd0);
`endif

    foreach (vecs[k]) step(vecs[k], k);

    // Reset in the cycle after an ack cancels the pulse.
    cyc(2'b01, r(0,22), 1'b0, 1'b0);
    cyc(2'b00, z, 1'b1, 1'b0);
    chk("ack pulse before rst", 32'(o_violation), 32'd1);
    @(negedge clk);
    drive(2'b00, z, z, 1'b0, z, 1'b0, 1'b1);
    #1;
    chk("rst after ack suppresses pulse", 32'(o_violation), 32'd0);
    @(posedge clk);
    #1;
    chk("rst after ack violation", 32'(o_violation), 32'd0);
    chk("rst after ack squash_vld", 32'(o_squash_vld), 32'd0);
    cyc(2'b00, z, 1'b0, 1'b0);

`ifdef MEMVIO_CNT_EN
    for (int n = 0; n < 3; n++) begin
      cyc(2'b01, r(0, 40 + n), 1'b0, 1'b0);
      cyc(2'b00, z, 1'b1, 1'b0);
    end
    chk("vio_count after 3", o_vio_count, 32'd3);
    @(negedge clk);
    dut.vio_cnt = 32'hFFFF_FFFF;
    cyc(2'b01, r(0,44), 1'b0, 1'b0);
    cyc(2'b00, z, 1'b1, 1'b0);
    chk("vio_count saturates", o_vio_count, 32'hFFFF_FFFF);
    cyc(2'b00, z, 1'b0, 1'b1);
    chk("vio_count reset", o_vio_count, 32'd0);
    cyc(2'b00, z, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
